// File: rtl/updown_mod_cnt.sv
// updown_mod_cnt: parametrised up/down counter with programmable modulus,
// clock enable, synchronous clamped load and wrap or saturate limit mode.
// tc is combinational, for cascading. ovf is a registered one-cycle pulse
// raised on every edge that meets the up/MAX or down/0 limit.
module updown_mod_cnt #(
  parameter int WIDTH = 4,
  parameter int MAX   = 15,
  parameter bit SAT   = 1'b0
) (
  input  logic             ck,
  input  logic             res,
  input  logic             en,
  input  logic             down,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  // Upper count limit at the counter's own width.
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] q_next;
  logic             ovf_next;
  logic             at_max;
  logic             at_zero;
  logic             limit_hit;
  logic [WIDTH-1:0] load_val;

  assign at_max  = (q == MAX_V);
  assign at_zero = (q == '0);

  // Detect a limit event for this edge and clamp out-of-range load values.
  always_comb begin
    limit_hit = en & ~load & ((~down & at_max) | (down & at_zero));
    load_val  = (d > MAX_V) ? MAX_V : d;
  end

  // tc is the unregistered limit condition, so a cascaded stage counts on
  // the same edge on which this stage wraps or saturates.
  assign tc = limit_hit;

  // Next-state selection: load has priority over counting; hold clears ovf.
  always_comb begin
    q_next   = q;
    ovf_next = 1'b0;
    if (load) begin
      q_next = load_val;
    end else if (en) begin
      if (limit_hit) begin
        ovf_next = 1'b1;
        if (!SAT) begin
          // Wrap to the opposite end of the 0..MAX range.
          q_next = down ? MAX_V : '0;
        end
      end else if (down) begin
        q_next = q - 1'b1;
      end else begin
        q_next = q + 1'b1;
      end
    end
  end

  // Count and overflow registers, cleared immediately by res.
  always_ff @(posedge ck or posedge res) begin
    if (res) begin
      q   <= '0;
      ovf <= 1'b0;
    end else begin
      q   <= q_next;
      ovf <= ovf_next;
    end
  end

endmodule

// File: tb/tb_updown_mod_cnt.sv
// Bench for updown_mod_cnt: a wrap instance and a saturate instance
// (WIDTH=4, MAX=9) share stimulus and are checked against an integer model.
module tb_updown_mod_cnt;

  localparam int W  = 4;
  localparam int MX = 9;

  logic         ck = 1'b0;
  logic         res = 1'b1;
  logic         en = 1'b0;
  logic         down = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] d = '0;
  logic [W-1:0] q_s [2];
  logic         tc_s [2];
  logic         ovf_s [2];

  int checks = 0;
  int errors = 0;
  int mq [2];
  int movf [2];

  always #5 ck = ~ck;

  updown_mod_cnt #(.WIDTH(W), .MAX(MX), .SAT(1'b0)) dut_wrap (
    .ck(ck), .res(res), .en(en), .down(down), .load(load), .d(d),
    .q(q_s[0]), .tc(tc_s[0]), .ovf(ovf_s[0])
  );

  updown_mod_cnt #(.WIDTH(W), .MAX(MX), .SAT(1'b1)) dut_sat (
    .ck(ck), .res(res), .en(en), .down(down), .load(load), .d(d),
    .q(q_s[1]), .tc(tc_s[1]), .ovf(ovf_s[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one edge for one instance (i=1 saturates).
  task automatic model_edge(input int i, input logic e, input logic dn, input logic ld, input int dv);
    int hit;
    if (ld) begin
      mq[i]   = (dv > MX) ? MX : dv;
      movf[i] = 0;
    end else if (e) begin
      hit     = dn ? (mq[i] == 0) : (mq[i] == MX);
      movf[i] = hit;
      if (i == 1) begin
        if (dn) mq[i] = (mq[i] > 0) ? mq[i] - 1 : 0;
        else    mq[i] = (mq[i] < MX) ? mq[i] + 1 : MX;
      end else begin
        mq[i] = (mq[i] + (dn ? MX : 1)) % (MX + 1);
      end
    end else begin
      movf[i] = 0;
    end
  endtask

  // One clock edge: apply inputs, check tc before the edge, q/ovf after it.
  task automatic step(input logic e, input logic dn, input logic ld, input int dv);
    int exp_tc;
    en = e; down = dn; load = ld; d = W'(dv);
    #1;
    for (int i = 0; i < 2; i++) begin
      exp_tc = (e && !ld && ((!dn && mq[i] == MX) || (dn && mq[i] == 0))) ? 1 : 0;
      chk(i == 0 ? "tc_wrap" : "tc_sat", 32'(tc_s[i]), 32'(exp_tc));
    end
    @(posedge ck);
    for (int i = 0; i < 2; i++) model_edge(i, e, dn, ld, dv);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk(i == 0 ? "q_wrap" : "q_sat", 32'(q_s[i]), 32'(mq[i]));
      chk(i == 0 ? "ovf_wrap" : "ovf_sat", 32'(ovf_s[i]), 32'(movf[i]));
    end
    $display("step en=%0d down=%0d load=%0d d=%0d -> wrap q=%0d ovf=%0d | sat q=%0d ovf=%0d",
             e, dn, ld, dv, q_s[0], ovf_s[0], q_s[1], ovf_s[1]);
  endtask

  // Assert res mid-cycle, check the immediate clear, hold over two edges.
  task automatic async_reset(input string tag);
    #3;
    res = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_q"}, 32'(q_s[i]), 32'd0);
      chk({tag, "_ovf"}, 32'(ovf_s[i]), 32'd0);
    end
    repeat (2) begin
      @(posedge ck);
      #1;
      for (int i = 0; i < 2; i++) chk({tag, "_hold_q"}, 32'(q_s[i]), 32'd0);
    end
    res = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mq[i] = 0;
      movf[i] = 0;
    end
    $display("reset %s asserted mid-cycle and released", tag);
  endtask

  initial begin
    mq[0] = 0; mq[1] = 0; movf[0] = 0; movf[1] = 0;

    // Power-on reset across two edges.
    repeat (2) @(posedge ck);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_q", 32'(q_s[i]), 32'd0);
      chk("rst_ovf", 32'(ovf_s[i]), 32'd0);
    end
    res = 1'b0;

    // Up 12 edges, then down 4 edges.
    repeat (12) step(1'b1, 1'b0, 1'b0, 0);
    repeat (4) step(1'b1, 1'b1, 1'b0, 0);

    // Saturate tests: up from 7 for 5 edges, down from 1 for 3 edges.
    step(1'b0, 1'b0, 1'b1, 7);
    repeat (5) step(1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b1, 1);
    repeat (3) step(1'b1, 1'b1, 1'b0, 0);

    // Load beats en; out-of-range load clamps to MAX.
    step(1'b1, 1'b0, 1'b1, 5);
    step(1'b1, 1'b1, 1'b1, 14);
    step(1'b1, 1'b0, 1'b1, 15);

    // Hold with direction toggling.
    for (int k = 0; k < 5; k++) step(1'b0, k[0], 1'b0, 0);

    // Reset mid-count at q=6, then resume counting.
    step(1'b0, 1'b0, 1'b1, 6);
    async_reset("rst6");
    repeat (3) step(1'b1, 1'b0, 1'b0, 0);

    // Reset while ovf is high.
    step(1'b0, 1'b0, 1'b1, 9);
    step(1'b1, 1'b0, 1'b0, 0);
    async_reset("rstovf");
    step(1'b1, 1'b1, 1'b0, 0);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(3) != 0), $urandom_range(1), ($urandom_range(7) == 0),
           int'($urandom_range(15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
